// File: rtl/gen_busy_sb.sv
// Busy-bit scoreboard: dispatch allocates entries, writeback releases them, flush clears all.
// Optional macro SB_REL_BYPASS_EN forwards a same-cycle release into alloc_ready/query_busy.
module gen_busy_sb #(
  parameter int unsigned NE = 32,
  parameter int unsigned AW = $clog2(NE),
  parameter int unsigned NQ = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             alloc_valid,
  input  logic [AW-1:0]    alloc_idx,
  output logic             alloc_ready,
  input  logic             release_valid,
  input  logic [AW-1:0]    release_idx,
  input  logic             flush,
  input  logic [NQ*AW-1:0] query_idx,
  output logic [NQ-1:0]    query_busy,
  output logic [NE-1:0]    busy_vec,
  output logic [AW:0]      busy_cnt,
  output logic             err
);

`ifdef SB_REL_BYPASS_EN
  localparam logic RelFwd = 1'b1;
`else
  localparam logic RelFwd = 1'b0;
`endif

  logic [NE-1:0] busy_q, busy_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [NE-1:0] rel_mask;
  logic [NE-1:0] fire_mask;
  logic [NE-1:0] eff;
  logic          fire;
  logic          rel_busy;
  logic          rel_bad;

  // Out-of-range indices match no entry, so their masks stay empty.
  always_comb begin
    rel_mask = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      rel_mask[i] = release_valid && (release_idx == AW'(i));
    end
  end

  assign eff = busy_q & ~(rel_mask & {NE{RelFwd}});

  always_comb begin
    alloc_ready = 1'b0;
    for (int unsigned i = 0; i < NE; i++) begin
      if (alloc_idx == AW'(i)) begin
        alloc_ready = ~eff[i];
      end
    end
  end

  always_comb begin
    query_busy = '0;
    for (int unsigned k = 0; k < NQ; k++) begin
      for (int unsigned i = 0; i < NE; i++) begin
        if (query_idx[k*AW +: AW] == AW'(i)) begin
          query_busy[k] = eff[i];
        end
      end
    end
  end

  // A fire under flush is dropped even though alloc_ready is still reported.
  assign fire = alloc_valid & alloc_ready & ~flush;

  always_comb begin
    fire_mask = '0;
    for (int unsigned i = 0; i < NE; i++) begin
      fire_mask[i] = fire && (alloc_idx == AW'(i));
    end
  end

  assign rel_busy = |(rel_mask & busy_q);
  assign rel_bad  = release_valid & ~flush & ~rel_busy;

  always_comb begin
    busy_d = '0;
    cnt_d  = '0;
    if (!flush) begin
      busy_d = (busy_q & ~rel_mask) | fire_mask;
      cnt_d  = cnt_q + (AW+1)'(fire) - (AW+1)'(rel_busy);
    end
    err_d = err_q | rel_bad;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_gen_busy_sb.sv
// Bench for gen_busy_sb: set-based reference model checked every negedge, plus literal pins.
module tb_gen_busy_sb;
  localparam int unsigned NE = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NQ = 2;
`ifdef SB_REL_BYPASS_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             alloc_valid = 1'b0;
  logic [AW-1:0]    alloc_idx = '0;
  logic             alloc_ready;
  logic             release_valid = 1'b0;
  logic [AW-1:0]    release_idx = '0;
  logic             flush = 1'b0;
  logic [NQ*AW-1:0] query_idx = '0;
  logic [NQ-1:0]    query_busy;
  logic [NE-1:0]    busy_vec;
  logic [AW:0]      busy_cnt;
  logic             err;

  int n_checks = 0;
  int n_fail   = 0;

  gen_busy_sb #(.NE(NE), .AW(AW), .NQ(NQ)) dut (
    .CLK(CLK), .RST(RST),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_ready(alloc_ready),
    .release_valid(release_valid), .release_idx(release_idx), .flush(flush),
    .query_idx(query_idx), .query_busy(query_busy),
    .busy_vec(busy_vec), .busy_cnt(busy_cnt), .err(err)
  );

  always #5 CLK = ~CLK;

  // Reference model: a set of busy entries and a sticky error bit.
  bit m_busy [NE];
  bit m_err = 1'b0;

  function automatic bit m_eff(input int idx);
    if (idx >= NE) return 1'b0;
    return m_busy[idx] && !(FWD && release_valid && int'(release_idx) == idx);
  endfunction

  function automatic bit m_ready();
    return (int'(alloc_idx) < NE) && !m_eff(int'(alloc_idx));
  endfunction

  function automatic int m_pop();
    int n = 0;
    for (int i = 0; i < NE; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [NE-1:0] m_vec();
    logic [NE-1:0] v = '0;
    for (int i = 0; i < NE; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NE; i++) m_busy[i] = 1'b0;
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NE; i++) m_busy[i] = 1'b0;
    end else begin
      bit fire;
      bit rel_ok;
      fire   = alloc_valid && m_ready();
      rel_ok = release_valid && int'(release_idx) < NE && m_busy[int'(release_idx)];
      if (release_valid && !rel_ok) m_err = 1'b1;
      if (rel_ok) m_busy[int'(release_idx)] = 1'b0;
      if (fire) m_busy[int'(alloc_idx)] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    chk("m_busy_vec", 64'(busy_vec), 64'(m_vec()));
    chk("m_busy_cnt", 64'(busy_cnt), 64'(m_pop()));
    chk("m_err", 64'(err), 64'(m_err));
    chk("m_alloc_ready", 64'(alloc_ready), 64'(m_ready()));
    for (int k = 0; k < NQ; k++) begin
      chk("m_query_busy", 64'(query_busy[k]), 64'(m_eff(int'(query_idx[k*AW +: AW]))));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit av, input int ai, input bit rv, input int ri, input bit fl,
                       input int q0, input int q1);
    alloc_valid   = av;
    alloc_idx     = AW'(ai);
    release_valid = rv;
    release_idx   = AW'(ri);
    flush         = fl;
    query_idx     = {AW'(q1), AW'(q0)};
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  initial begin
    logic [NE-1:0] vec_snap;
    logic [AW:0]   cnt_snap;
    #1;
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    chk("rst_busy_cnt", 64'(busy_cnt), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    tick(); tick();
    RST = 1'b0;

    // Async reset mid-stream with entries 4..7 busy.
    for (int i = 4; i < 8; i++) begin
      drive(1, i, 0, 0, 0, 0, 0);
      tick();
    end
    idle();
    chk("pre_rst_vec", 64'(busy_vec), 64'hF0);
    chk("pre_rst_cnt", 64'(busy_cnt), 64'd4);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_vec", 64'(busy_vec), 64'h0);
    chk("async_rst_cnt", 64'(busy_cnt), 64'h0);
    chk("async_rst_err", 64'(err), 64'h0);
    tick();
    RST = 1'b0;

    // Fill every entry, then hit the full boundary.
    for (int i = 0; i < NE; i++) begin
      drive(1, i, 0, 0, 0, i, 31 - i);
      tick();
    end
    chk("full_cnt", 64'(busy_cnt), 64'd32);
    chk("full_vec", 64'(busy_vec), 64'hFFFF_FFFF);
    drive(1, 5, 0, 0, 0, 0, 0);
    #1;
    chk("full_ready", 64'(alloc_ready), 64'h0);
    tick();
    chk("full_stall_cnt", 64'(busy_cnt), 64'd32);
    drive(1, 5, 1, 5, 0, 5, 0);
    #1;
    chk("same_idx_ready", 64'(alloc_ready), 64'(FWD));
    tick();
    chk("same_idx_cnt", 64'(busy_cnt), FWD ? 64'd32 : 64'd31);
    chk("same_idx_bit5", 64'(busy_vec[5]), 64'(FWD));

    // Query forwarding of a release on entry 3.
    drive(0, 0, 1, 3, 0, 3, 4);
    #1;
    chk("query_rel_cycle", 64'(query_busy[0]), 64'(!FWD));
    chk("query_other", 64'(query_busy[1]), 64'h1);
    tick();
    drive(0, 0, 0, 0, 0, 3, 4);
    #1;
    chk("query_next_cycle", 64'(query_busy[0]), 64'h0);
    chk("query_cnt", 64'(busy_cnt), FWD ? 64'd31 : 64'd30);
    idle();
    pulse_reset();

    // Flush beats alloc and release in the same cycle.
    for (int i = 0; i < 10; i++) begin
      drive(1, i, 0, 0, 0, 0, 0);
      tick();
    end
    chk("pre_flush_cnt", 64'(busy_cnt), 64'd10);
    drive(1, 12, 1, 2, 1, 12, 2);
    #1;
    chk("flush_ready", 64'(alloc_ready), 64'h1);
    tick();
    idle();
    chk("flush_vec", 64'(busy_vec), 64'h0);
    chk("flush_cnt", 64'(busy_cnt), 64'h0);
    chk("flush_err", 64'(err), 64'h0);

    // Different-index alloc and release together.
    for (int i = 0; i < 6; i++) begin
      drive(1, i, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 9, 1, 4, 0, 9, 4);
    tick();
    idle();
    chk("conc_vec", 64'(busy_vec), 64'h22F);
    chk("conc_cnt", 64'(busy_cnt), 64'd6);

    // Release of a free entry sets the sticky error only.
    vec_snap = busy_vec;
    cnt_snap = busy_cnt;
    drive(0, 0, 1, 7, 0, 7, 0);
    tick();
    idle();
    chk("misuse_err", 64'(err), 64'h1);
    chk("misuse_vec", 64'(busy_vec), 64'(vec_snap));
    chk("misuse_cnt", 64'(busy_cnt), 64'(cnt_snap));
    tick(); tick();
    chk("misuse_sticky", 64'(err), 64'h1);
    pulse_reset();
    chk("err_cleared", 64'(err), 64'h0);

    // Directed mixed traffic sweep checked by the model.
    for (int i = 0; i < 96; i++) begin
      drive((i % 3) != 2, (i * 7) % NE, (i % 4) == 1, (i * 11 + 3) % NE, (i % 37) == 36,
            (i * 5) % NE, (i * 13 + 1) % NE);
      tick();
    end
    idle();
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
